// File: rtl/rv_io_pkg.sv
// rv_io_pkg
// Shared types and constants for the IO peripheral bus arbiter.
//   ioState_e : arbiter FSM states (IDLE/ADDR/WAIT/RESP)
//   IO_AW     : peripheral address width
//   IO_MW     : byte-mask width
//   CNT_W     : timeout counter width
//   ERR_BIT   : fill bit replicated across the data width for error responses
package rv_io_pkg;

  localparam int IO_AW = 12;
  localparam int IO_MW = 8;
  localparam int CNT_W = 8;

  // Error responses carry all ones on the read data bus.
  localparam logic ERR_BIT = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } ioState_e;

endpackage

// File: rtl/rv_io_arbiter_if.sv
// rv_io_arbiter_if
// Bundles the requester-side (s_*) and peripheral-side (m_*) handshake
// signals of the IO bus arbiter.
//   master modport : the arbiter's view (drives grants, responses, m_* requests)
//   slave modport  : the environment's view (requesters plus the peripheral)
// Parameters: NREQ requesters, RV-bit data.
interface rv_io_arbiter_if
  import rv_io_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int RV   = 64
) ();

  logic [NREQ-1:0]       s_addr_req;
  logic [NREQ-1:0]       s_addr_ack;
  logic [NREQ*IO_AW-1:0] s_addr;
  logic [NREQ-1:0]       s_read;
  logic [NREQ*IO_MW-1:0] s_mask;
  logic [NREQ*RV-1:0]    s_wdata;
  logic [NREQ-1:0]       s_data_req;
  logic [NREQ-1:0]       s_data_ack;
  logic [RV-1:0]         s_rdata;
  logic                  s_err;
  logic                  bus_error;

  logic                  m_addr_req;
  logic                  m_addr_ack;
  logic [IO_AW-1:0]      m_addr;
  logic                  m_read;
  logic [IO_MW-1:0]      m_mask;
  logic [RV-1:0]         m_wdata;
  logic                  m_data_req;
  logic                  m_data_ack;
  logic [RV-1:0]         m_rdata;

  modport master (
    input  s_addr_req, s_addr, s_read, s_mask, s_wdata, s_data_ack,
    output s_addr_ack, s_data_req, s_rdata, s_err, bus_error,
    output m_addr_req, m_addr, m_read, m_mask, m_wdata, m_data_ack,
    input  m_addr_ack, m_data_req, m_rdata
  );

  modport slave (
    output s_addr_req, s_addr, s_read, s_mask, s_wdata, s_data_ack,
    input  s_addr_ack, s_data_req, s_rdata, s_err, bus_error,
    input  m_addr_req, m_addr, m_read, m_mask, m_wdata, m_data_ack,
    output m_addr_ack, m_data_req, m_rdata
  );

endinterface

// File: rtl/rv_io_rr_pick.sv
// rv_io_rr_pick
// Combinational round-robin picker.
//   req_i   : request vector, one bit per requester
//   ptr_i   : index of the requester with highest priority this cycle
//   grant_o : one-hot winner (all zero when nothing is requested)
//   idx_o   : binary index of the winner (0 when nothing is requested)
module rv_io_rr_pick
  import rv_io_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   ptr_i,
  output logic [NREQ-1:0] grant_o,
  output logic [IW-1:0]   idx_o
);

  logic found;
  int   cand;

  // Walk the requesters starting at the pointer, wrapping around, and take
  // the first one found.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    cand    = 0;
    for (int k = 0; k < NREQ; k++) begin
      cand = (int'(ptr_i) + k) % NREQ;
      if (!found && req_i[IW'(cand)]) begin
        found                = 1'b1;
        grant_o[IW'(cand)]   = 1'b1;
        idx_o                = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/rv_io_arbiter.sv
// rv_io_arbiter
// Arbitrates the 12-bit-address IO peripheral bus between NREQ requesters,
// one transaction at a time, round-robin fair. A timeout retires
// transactions that no peripheral claims.
//   clk, reset : clock and synchronous active-high reset
//   bus        : rv_io_arbiter_if master modport carrying the requester
//                handshakes (s_*), the peripheral handshakes (m_*) and the
//                bus_error pulse
// Parameters: NREQ requesters (2..8), RV-bit data, TIMEOUT cycles (1..255)
// spent in ADDR or WAIT before a transaction is error-retired.
module rv_io_arbiter
  import rv_io_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int RV      = 64,
  parameter int TIMEOUT = 255
) (
  input logic              clk,
  input logic              reset,
  rv_io_arbiter_if.master  bus
);

  localparam int IW = $clog2(NREQ);

  // The counter is 0 in the first cycle of ADDR/WAIT, so the last allowed
  // cycle is the one where it holds TIMEOUT-1; that gives exactly TIMEOUT
  // cycles in the state before retiring.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  ioState_e          state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IW-1:0]     grantIdx_q, grantIdx_d;
  logic [IW-1:0]     lastGrant_q, lastGrant_d;
  logic [IO_AW-1:0]  addr_q, addr_d;
  logic              read_q, read_d;
  logic [IO_MW-1:0]  mask_q, mask_d;
  logic [RV-1:0]     wdata_q, wdata_d;
  logic [RV-1:0]     rdata_q, rdata_d;
  logic              err_q, err_d;

  logic [IW-1:0]     prioPtr;
  logic [NREQ-1:0]   pickGrant;
  logic [IW-1:0]     pickIdx;
  logic              timeoutHit;

  // Priority starts one past the last winner; lastGrant resets to NREQ-1 so
  // requester 0 is first in line out of reset.
  assign prioPtr    = (lastGrant_q == IW'(NREQ - 1)) ? '0 : lastGrant_q + 1'b1;
  assign timeoutHit = (cnt_q == CNT_LAST);

  rv_io_rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) picker (
    .req_i   (bus.s_addr_req),
    .ptr_i   (prioPtr),
    .grant_o (pickGrant),
    .idx_o   (pickIdx)
  );

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      grantIdx_q  <= '0;
      lastGrant_q <= IW'(NREQ - 1);
      addr_q      <= '0;
      read_q      <= 1'b0;
      mask_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      grantIdx_q  <= grantIdx_d;
      lastGrant_q <= lastGrant_d;
      addr_q      <= addr_d;
      read_q      <= read_d;
      mask_q      <= mask_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
    end
  end

  // Next-state and output logic. Every output defaults to 0 and is only
  // driven in the state that owns it. A same-cycle ack/data always takes
  // precedence over the timeout.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    grantIdx_d  = grantIdx_q;
    lastGrant_d = lastGrant_q;
    addr_d      = addr_q;
    read_d      = read_q;
    mask_d      = mask_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    err_d       = err_q;

    bus.s_addr_ack = '0;
    bus.s_data_req = '0;
    bus.s_rdata    = '0;
    bus.s_err      = 1'b0;
    bus.bus_error  = 1'b0;
    bus.m_addr_req = 1'b0;
    bus.m_addr     = '0;
    bus.m_read     = 1'b0;
    bus.m_mask     = '0;
    bus.m_wdata    = '0;
    bus.m_data_ack = 1'b0;

    unique case (state_q)
      IDLE: begin
        // No grant is handed out while reset is held, so a requester never
        // sees an ack for a transaction that reset then discards.
        if (!reset && (|bus.s_addr_req)) begin
          bus.s_addr_ack = pickGrant;
          addr_d         = bus.s_addr[int'(pickIdx)*IO_AW +: IO_AW];
          read_d         = bus.s_read[pickIdx];
          mask_d         = bus.s_mask[int'(pickIdx)*IO_MW +: IO_MW];
          wdata_d        = bus.s_wdata[int'(pickIdx)*RV +: RV];
          grantIdx_d     = pickIdx;
          lastGrant_d    = pickIdx;
          cnt_d          = '0;
          state_d        = ADDR;
        end
      end

      ADDR: begin
        bus.m_addr_req = 1'b1;
        bus.m_addr     = addr_q;
        bus.m_read     = read_q;
        bus.m_mask     = mask_q;
        bus.m_wdata    = wdata_q;
        if (bus.m_addr_ack) begin
          cnt_d   = '0;
          state_d = read_q ? WAIT : IDLE;
        end else if (timeoutHit) begin
          bus.bus_error = 1'b1;
          if (read_q) begin
            rdata_d = {RV{ERR_BIT}};
            err_d   = 1'b1;
            state_d = RESP;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      WAIT: begin
        bus.m_data_ack = bus.m_data_req;
        if (bus.m_data_req) begin
          rdata_d = bus.m_rdata;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (timeoutHit) begin
          bus.bus_error = 1'b1;
          rdata_d       = {RV{ERR_BIT}};
          err_d         = 1'b1;
          state_d       = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      RESP: begin
        bus.s_data_req[grantIdx_q] = 1'b1;
        bus.s_rdata                = rdata_q;
        bus.s_err                  = err_q;
        if (bus.s_data_ack[grantIdx_q]) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule
